// File: rtl/cachebus_line_responder_pkg.sv
// Shared types for the cache line-bus memory responder.
package cachebus_line_responder_pkg;

   typedef enum logic [2:0] {IDLE, WAIT, RBEAT, WBEAT, ACK} cachebus_resp_state_t;

   localparam logic [1:0] CACHEBUS_READ  = 2'b10;
   localparam logic [1:0] CACHEBUS_WRITE = 2'b01;

endpackage

// File: rtl/cachebus_line_responder_beat_ram.sv
// Beat-wide 1R1W storage: combinational read, synchronous write, never cleared.
module cachebus_beat_ram #(
   parameter int BEATLEN  = 64,
   parameter int MEMBEATS = 4096,
   parameter int ADRW     = $clog2(MEMBEATS)
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADRW-1:0]    wAdr,
   input  logic [BEATLEN-1:0] wData,
   input  logic [ADRW-1:0]    rAdr,
   output logic [BEATLEN-1:0] rData
);

   logic [BEATLEN-1:0] mem [MEMBEATS];

   always_ff @(posedge clk) begin
      if (we) mem[wAdr] <= wData;
   end

   assign rData = mem[rAdr];

endmodule

// File: rtl/cachebus_line_responder.sv
// Memory-side responder for the cache line bus: services line fetches and
// writebacks one beat per cycle from a local beat-wide array.
module cachebus_line_responder
   import cachebus_line_responder_pkg::*;
#(
   parameter int PA_BITS  = 34,
   parameter int LINELEN  = 512,
   parameter int BEATLEN  = 64,
   parameter int MEMBEATS = 4096,
   parameter int LATENCY  = 2,
   parameter int LOGBWPL  = $clog2(LINELEN/BEATLEN)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [1:0]                  CacheBusRW,
   input  logic [PA_BITS-1:0]          CacheBusAdr,
   input  logic [BEATLEN-1:0]          ReadDataWord,
   output logic [LINELEN-1:0]          FetchBuffer,
   output logic [LOGBWPL-1:0]          BeatCount,
   output logic                        SelBusBeat,
   output logic                        CacheBusAck,
   output logic                        BusBusy,
   input  logic                        InitEn,
   input  logic [$clog2(MEMBEATS)-1:0] InitAdr,
   input  logic [BEATLEN-1:0]          InitData
);

   localparam int MEMW      = $clog2(MEMBEATS);
   localparam int OFFSETLEN = $clog2(LINELEN/8);
   localparam int BASEW     = MEMW - LOGBWPL;
   localparam int LATW      = $clog2(LATENCY + 2);
   localparam logic [LOGBWPL-1:0] LASTBEAT = LOGBWPL'(LINELEN/BEATLEN - 1);
   localparam logic [LATW-1:0]    LATLAST  = LATW'(LATENCY > 0 ? LATENCY - 1 : 0);

   cachebus_resp_state_t state, nextState;

   logic [BASEW-1:0]   lineBase;
   logic               dirWrite;
   logic [LATW-1:0]    latCnt;
   logic [MEMW-1:0]    beatIdx;
   logic               isRead, isWrite, request, lastBeat;
   logic               ramWe;
   logic [MEMW-1:0]    ramWAdr;
   logic [BEATLEN-1:0] ramWData, ramRData;
   logic               unusedAdrBits;

   assign isRead   = (CacheBusRW & CACHEBUS_READ) != '0;
   assign isWrite  = (CacheBusRW & CACHEBUS_WRITE) != '0;
   assign request  = isRead | isWrite;
   assign lastBeat = BeatCount == LASTBEAT;
   // Only the low line-base bits survive the modulo-MEMBEATS beat index.
   assign beatIdx  = {lineBase, BeatCount};
   assign unusedAdrBits = ^{CacheBusAdr[OFFSETLEN-1:0], CacheBusAdr[PA_BITS-1:OFFSETLEN+BASEW]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nextState;
   end

   always_comb begin
      nextState   = state;
      SelBusBeat  = 1'b0;
      CacheBusAck = 1'b0;
      BusBusy     = 1'b1;
      ramWe       = 1'b0;
      ramWAdr     = beatIdx;
      ramWData    = ReadDataWord;
      case (state)
         IDLE: begin
            BusBusy = 1'b0;
            if (request) begin
               if (LATENCY > 0)  nextState = WAIT;
               else if (isWrite) nextState = WBEAT;
               else              nextState = RBEAT;
            end else if (InitEn) begin
               ramWe    = 1'b1;
               ramWAdr  = InitAdr;
               ramWData = InitData;
            end
         end
         WAIT: begin
            if (latCnt == LATLAST) nextState = dirWrite ? WBEAT : RBEAT;
         end
         RBEAT: begin
            SelBusBeat = 1'b1;
            if (lastBeat) nextState = ACK;
         end
         WBEAT: begin
            SelBusBeat = 1'b1;
            ramWe      = 1'b1;
            if (lastBeat) nextState = ACK;
         end
         ACK: begin
            CacheBusAck = 1'b1;
            nextState   = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lineBase    <= '0;
         dirWrite    <= 1'b0;
         latCnt      <= '0;
         BeatCount   <= '0;
         FetchBuffer <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (request) begin
                  lineBase <= CacheBusAdr[OFFSETLEN +: BASEW];
                  dirWrite <= isWrite;
                  latCnt   <= '0;
               end
            end
            WAIT: latCnt <= latCnt + LATW'(1);
            RBEAT: begin
               FetchBuffer[int'(BeatCount)*BEATLEN +: BEATLEN] <= ramRData;
               BeatCount <= lastBeat ? '0 : BeatCount + LOGBWPL'(1);
            end
            WBEAT: BeatCount <= lastBeat ? '0 : BeatCount + LOGBWPL'(1);
            default: ;
         endcase
      end
   end

   cachebus_beat_ram #(
      .BEATLEN (BEATLEN),
      .MEMBEATS(MEMBEATS),
      .ADRW    (MEMW)
   ) beatRam (
      .clk  (clk),
      .we   (ramWe),
      .wAdr (ramWAdr),
      .wData(ramWData),
      .rAdr (beatIdx),
      .rData(ramRData)
   );

endmodule

// File: tb/tb_cachebus_line_responder.sv
// Bench for cachebus_line_responder: default-latency and zero-latency instances
// driven from a transaction table, with a reference storage model and fetch scoreboard.
module tb_cachebus_line_responder;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit          useZ = 1'b0;
   logic [1:0]  rwCmd = 2'b00;
   logic [33:0] adrCmd = '0;
   logic        initEn = 1'b0;
   logic [11:0] initAdr = '0;
   logic [63:0] initData = '0, wbBase = '0;

   logic [1:0]   rwA, rwZ;
   logic [33:0]  adrA, adrZ;
   logic [63:0]  rdwA, rdwZ;
   logic         initEnA, initEnZ;
   logic [511:0] fbA, fbZ, fbS;
   logic [2:0]   bcA, bcZ, bcS;
   logic         selA, selZ, selS, ackA, ackZ, ackS, busyA, busyZ, busyS;

   assign rwA     = useZ ? 2'b00 : rwCmd;
   assign rwZ     = useZ ? rwCmd : 2'b00;
   assign adrA    = adrCmd;
   assign adrZ    = adrCmd;
   assign initEnA = initEn & ~useZ;
   assign initEnZ = initEn & useZ;
   assign rdwA    = wbBase + 64'(bcA);
   assign rdwZ    = wbBase + 64'(bcZ);
   assign fbS     = useZ ? fbZ : fbA;
   assign bcS     = useZ ? bcZ : bcA;
   assign selS    = useZ ? selZ : selA;
   assign ackS    = useZ ? ackZ : ackA;
   assign busyS   = useZ ? busyZ : busyA;

   cachebus_line_responder dutA (
      .clk(clk), .reset_n(reset_n), .CacheBusRW(rwA), .CacheBusAdr(adrA),
      .ReadDataWord(rdwA), .FetchBuffer(fbA), .BeatCount(bcA), .SelBusBeat(selA),
      .CacheBusAck(ackA), .BusBusy(busyA), .InitEn(initEnA), .InitAdr(initAdr),
      .InitData(initData)
   );

   cachebus_line_responder #(.LATENCY(0)) dutZ (
      .clk(clk), .reset_n(reset_n), .CacheBusRW(rwZ), .CacheBusAdr(adrZ),
      .ReadDataWord(rdwZ), .FetchBuffer(fbZ), .BeatCount(bcZ), .SelBusBeat(selZ),
      .CacheBusAck(ackZ), .BusBusy(busyZ), .InitEn(initEnZ), .InitAdr(initAdr),
      .InitData(initData)
   );

   int checks = 0;
   int errors = 0;
   logic [63:0]  model [2][4096];
   logic [511:0] expQ [$];

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int unsigned beatIndex(input logic [33:0] adr, input int unsigned b);
      logic [40:0] t;
      t = 41'(adr >> 6) * 41'd8 + 41'(b);
      return 32'(t % 41'd4096);
   endfunction

   function automatic logic [511:0] buildLine(input bit z, input logic [33:0] adr);
      logic [511:0] l;
      for (int b = 0; b < 8; b++) l[b*64 +: 64] = model[z][beatIndex(adr, b)];
      return l;
   endfunction

   task automatic initWrite(input bit z, input int unsigned idx, input logic [63:0] d);
      useZ = z; initEn = 1'b1; initAdr = 12'(idx); initData = d;
      model[z][idx] = d;
      @(negedge clk);
      initEn = 1'b0;
   endtask

   // Leaves the request asserted on return so a caller can chain back-to-back.
   task automatic runTxn(input bit z, input logic [1:0] rw, input logic [33:0] adr,
                         input logic [63:0] base, input int expAck, output int ackCyc);
      int  c;
      bit  done;
      bit  expSel;
      logic [511:0] expLine;
      useZ = z; rwCmd = rw; adrCmd = adr; wbBase = base;
      ackCyc = -1;
      if (rw[0]) begin
         for (int b = 0; b < 8; b++) model[z][beatIndex(adr, b)] = base + 64'(b);
      end else begin
         expQ.push_back(buildLine(z, adr));
      end
      if (ackS) @(negedge clk);
      c = 1; done = 1'b0;
      chk("busy_accept_cycle", busyS, 0);
      while (!done && c < 40) begin
         @(negedge clk);
         initEn = 1'b0;
         c++;
         expSel = (c >= expAck - 8) && (c < expAck);
         chk("busy", busyS, 1);
         chk("selBusBeat", selS, expSel);
         chk("beatCount", bcS, expSel ? 3'(c - (expAck - 8)) : 3'd0);
         chk("ack", ackS, c == expAck);
         if (ackS) begin
            done = 1'b1;
            ackCyc = cyc;
         end
      end
      if (!done) chk("ack_timeout", 0, 1);
      if (!rw[0] && expQ.size() > 0) begin
         expLine = expQ.pop_front();
         if (done) chk("fetchBuffer", fbS, expLine);
      end
   endtask

   typedef struct {
      bit          z;
      logic [1:0]  rw;
      logic [33:0] adr;
      logic [63:0] base;
      int          expAck;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int ack1, ack2, waitN;

      vecs[0] = '{1'b0, 2'b10, 34'h200,  64'h0,         12};
      vecs[1] = '{1'b0, 2'b01, 34'h400,  64'hA5A5_0000, 12};
      vecs[2] = '{1'b0, 2'b10, 34'h400,  64'h0,         12};
      vecs[3] = '{1'b0, 2'b11, 34'h240,  64'hBEEF_0000, 12};
      vecs[4] = '{1'b0, 2'b10, 34'h240,  64'h0,         12};
      vecs[5] = '{1'b1, 2'b10, 34'h200,  64'h0,         10};
      vecs[6] = '{1'b1, 2'b01, 34'hFFC0, 64'hC0DE_0000, 10};
      vecs[7] = '{1'b1, 2'b10, 34'h7FC0, 64'h0,         10};
      vecs[8] = '{1'b1, 2'b10, 34'h0,    64'h0,         10};

      repeat (3) @(negedge clk);
      chk("rst_fbA", fbA, 0);
      chk("rst_bcA", bcA, 0);
      chk("rst_selA", selA, 0);
      chk("rst_ackA", ackA, 0);
      chk("rst_busyA", busyA, 0);
      chk("rst_busyZ", busyZ, 0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         initWrite(1'b0, 32'h40 + i, 64'h1111_0000 + 64'(i));
         initWrite(1'b1, 32'h40 + i, 64'h2222_0000 + 64'(i));
         initWrite(1'b1, i, 64'h3333_0000 + 64'(i));
         initWrite(1'b1, 4088 + i, 64'h4444_0000 + 64'(i));
         initWrite(1'b0, 32'h100 + i, 64'h5555_0000 + 64'(i));
      end

      for (int v = 0; v < 9; v++) begin
         runTxn(vecs[v].z, vecs[v].rw, vecs[v].adr, vecs[v].base, vecs[v].expAck, ack1);
         rwCmd = 2'b00;
         @(negedge clk);
      end

      // Writeback victim then fetch, accepted in the IDLE cycle right after Ack.
      runTxn(1'b0, 2'b01, 34'h600, 64'h6666_0000, 12, ack1);
      runTxn(1'b0, 2'b10, 34'h200, 64'h0, 12, ack2);
      rwCmd = 2'b00;
      chk("b2b_ack_spacing", 32'(ack2 - ack1), 32'd12);
      @(negedge clk);

      // Backdoor write alongside a request must be dropped.
      initEn = 1'b1; initAdr = 12'h40; initData = 64'hDEAD_BEEF_DEAD_BEEF;
      runTxn(1'b0, 2'b10, 34'h200, 64'h0, 12, ack1);
      rwCmd = 2'b00;
      initEn = 1'b0;
      @(negedge clk);

      // Reset while beat 4 of a writeback is pending.
      useZ = 1'b0; wbBase = 64'h7777_0000; adrCmd = 34'h800; rwCmd = 2'b01;
      waitN = 0;
      while (!(selA && bcA == 3'd4) && waitN < 20) begin
         @(negedge clk);
         waitN++;
      end
      chk("wbeat4_reached", waitN < 20, 1);
      reset_n = 1'b0;
      #1;
      chk("midrst_fb", fbA, 0);
      chk("midrst_bc", bcA, 0);
      chk("midrst_sel", selA, 0);
      chk("midrst_ack", ackA, 0);
      chk("midrst_busy", busyA, 0);
      for (int b = 0; b < 4; b++) model[0][32'h100 + b] = 64'h7777_0000 + 64'(b);
      rwCmd = 2'b00;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      runTxn(1'b0, 2'b10, 34'h800, 64'h0, 12, ack1);
      rwCmd = 2'b00;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cachebus_line_responder.md
Name: cachebus_line_responder

Overview:
- Memory-side responder for the cache line-bus interface: services line fetches (CacheBusRW=10) and line writebacks (CacheBusRW=01) issued by the I$/D$.
- Backed by a beat-wide synchronous storage array with a configurable first-beat latency.
- Supplies BeatCount/SelBusBeat so the cache selects writeback words, assembles fetched lines into FetchBuffer, and signals completion with CacheBusAck.
- Used as the backing store in cache unit benches and in the bus-less fast-memory configuration.

Parameters:
- PA_BITS, 34, physical address width
- LINELEN, 512, cache line length in bits
- BEATLEN, 64, bits per beat; equals cache WORDLEN/MUXINTERVAL
- MEMBEATS, 4096, storage depth in beats; power of 2
- LATENCY, 2, wait cycles between request acceptance and first beat; 0 allowed
- LOGBWPL, $clog2(LINELEN/BEATLEN), beat counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- CacheBusRW  in  2  [1] line fetch, [0] line writeback; held until CacheBusAck
- CacheBusAdr  in  PA_BITS  line address; offset bits ignored
- ReadDataWord  in  BEATLEN  writeback word, driven by the cache from BeatCount in the same cycle
- FetchBuffer  out  LINELEN  assembled fetched line
- BeatCount  out  LOGBWPL  current beat index
- SelBusBeat  out  1  cache uses BeatCount for its word offset
- CacheBusAck  out  1  one-cycle completion pulse
- BusBusy  out  1  high in every state except IDLE
- InitEn  in  1  backdoor write strobe; accepted only in IDLE
- InitAdr  in  $clog2(MEMBEATS)  backdoor beat index
- InitData  in  BEATLEN  backdoor write data

Behaviour:
- Reset (async, reset_n=0): state=IDLE; FetchBuffer=0, BeatCount=0, SelBusBeat=0, CacheBusAck=0, BusBusy=0, latency counter=0.
  - Storage array is not cleared.
  - Reset asserted mid-burst aborts the burst. Beats already written remain in storage.
- States: IDLE, WAIT, RBEAT, WBEAT, ACK.
- IDLE:
  - If CacheBusRW!=00: latch line base = CacheBusAdr[PA_BITS-1:OFFSETLEN] and latch the direction.
    - Next state is WAIT if LATENCY>0, else RBEAT or WBEAT.
  - CacheBusRW=11 is illegal; writeback takes priority.
  - If InitEn and CacheBusRW=00: storage[InitAdr] <= InitData. If a request is also present, InitEn is ignored.
- WAIT: counts LATENCY cycles. BeatCount=0, SelBusBeat=0, then moves to RBEAT or WBEAT.
- Beat index: storage index = ({line base, beat} ) mod MEMBEATS. Wrap-around past the top of storage is silent.
- RBEAT: one beat per cycle, with SelBusBeat=1.
  - FetchBuffer[BeatCount*BEATLEN +: BEATLEN] <= storage[index].
  - BeatCount increments. After beat LINELEN/BEATLEN-1, BeatCount returns to 0 and state goes to ACK.
  - Read data has zero storage-read latency as seen from the beat.
- WBEAT: one beat per cycle, with SelBusBeat=1; storage[index] <= ReadDataWord sampled in the same cycle. Sequencing is the same as RBEAT, ending in ACK.
- ACK: CacheBusAck=1 for exactly one cycle.
  - FetchBuffer holds the complete line and stays stable until the next RBEAT.
  - CacheBusRW is ignored in this cycle. Next state is IDLE.
- Back-to-back: a request present in the IDLE cycle after ACK is accepted there (writeback-then-fetch for dirty victims).
- Line latency = 1 (accept) + LATENCY + LINELEN/BEATLEN + 1 (ack) cycles.
  - Defaults: 1+2+8+1 = 12 cycles from the first RW cycle to the Ack cycle, inclusive.
- Changes to CacheBusRW or CacheBusAdr after acceptance are ignored until IDLE.

Decomposition:
- Shared package (cvw): enum cachebus_resp_state_t {IDLE, WAIT, RBEAT, WBEAT, ACK}, plus localparams CACHEBUS_READ=2'b10 and CACHEBUS_WRITE=2'b01.
- One sub-module: cachebus_beat_ram, a 1R1W beat-wide array with combinational read and synchronous write. The init write and the WBEAT write share the single write port through a mux.

Test Plan:
- Fetch: InitEn preloads beats 0x40..0x47 = 0x1111_0000+i; then RW=10, Adr=0x200 -> BusBusy high, SelBusBeat high cycles 4-11, BeatCount 0..7, Ack single pulse at cycle 12, FetchBuffer[63:0]=0x11110000 and [511:448]=0x11110007.
- Writeback: RW=01, Adr=0x400, ReadDataWord=0xA5A5_0000+BeatCount -> after Ack, a fetch of 0x400 returns those 8 words in order.
- Writeback followed by fetch: RW=01 then RW=10 (different line) in the cycle after Ack -> accepted without an idle gap; the second Ack arrives 12 cycles after the first.
- LATENCY=0 build: fetch -> first beat in cycle 2, Ack in cycle 10; wrap test with Adr mapping to beat MEMBEATS-8 -> indices MEMBEATS-8..MEMBEATS-1, no spill.
- Reset mid-WBEAT after beat 3: drop reset_n -> all outputs 0 immediately, state IDLE; beats 0-3 updated, beats 4-7 hold their prior values.
- RW=11 -> treated as writeback; InitEn concurrent with a request -> storage unchanged at InitAdr.
